demux4_stream: RTL and testbench
================================

Name: demux4_stream

Overview:
- Sequential 1-to-4 demultiplexer: the reverse direction of the team's 2-bit 4:1 selector.
- Accepts one data word per cycle on a valid/ready input stream and steers it to one of four output lanes chosen by sel.
- Each lane has a 2-entry FIFO buffer, so a stalled lane does not block other lanes beyond that lane's own backpressure.
- Sits between a single producer and four independent consumers.

Parameters:
- W, 2, data width per word (default matches the team's 2-bit mux datapath).
- DEPTH, 2, entries per lane buffer; fixed at 2 and not required to be legal at other values.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  W  word to route.
- in_sel  input  2  destination lane (00→lane0, 01→lane1, 10→lane2, 11→lane3).
- out_valid  output  4  bit i: lane i head entry valid.
- out_ready  input  4  bit i: consumer i takes the head entry.
- out_data  output  4*W  lane i word at [i*W +: W].
- Optional, only with DEMUX4_CNT_EN:
  - cnt_clr  input  1  clears the counters.
  - lane_cnt  output  4*8  lane i count at [i*8 +: 8].

Interface decisions (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset: when rst=1 at a clk edge, all lane counts go to 0, out_valid=4'b0, out_data=0, and lane_cnt=0 if present. The reset wins over any same-cycle push or pop. A reset mid-stream discards all buffered words.
- in_ready: combinational, equal to (count[in_sel] != 2). It depends only on in_sel and lane state, not on in_valid. It is 0 during the cycle rst is asserted only if the lane is full; its value is irrelevant then because reset wins.
- Push: in_valid && in_ready at an edge writes in_data into lane in_sel's tail. No other lane changes.
- Pop: out_valid[i] && out_ready[i] at an edge removes lane i's head. All four lanes can pop in the same cycle.
- out_valid[i] = (count[i] != 0). out_data lane i shows the head entry, registered. Data is stable while valid and not popped.
- Latency: a word accepted at edge N is visible on out_valid/out_data at edge N+1, i.e. one cycle.
  - There is no combinational path from in_data to out_data.
  - There is no combinational path from out_ready to in_ready. A lane full at the start of a cycle stays unready in that cycle even if it pops.
- Simultaneous push and pop on the same lane:
  - count=1: count stays 1, the new word becomes the head on the next cycle, and order is preserved.
  - count=2: no push is possible.
  - count=0: push only.
- Ordering: FIFO order within each lane. No ordering guarantee across lanes.
- Lane state: 2-entry circular buffer with 1-bit read/write pointers that wrap 1→0, plus a 2-bit count in the range 0..2. Full means count==2.
- in_data and in_sel are ignored when in_valid=0. X on these fields with in_valid=0 must not corrupt state.

Optional Feature:
- Macro: DEMUX4_CNT_EN.
- Defined:
  - Adds cnt_clr and lane_cnt.
  - Each lane has an 8-bit counter of accepted pushes. It increments on a push to that lane and wraps 255→0.
  - cnt_clr=1 zeroes all counters, taking priority over a same-cycle increment.
  - rst also zeroes the counters.
- Undefined: the ports and counters do not exist, and the rest of the behaviour is identical.

Decomposition:
- Package demux4_pkg:
  - localparam NLANES=4.
  - typedef logic [1:0] lane_sel_t.
  - typedef logic [1:0] lane_cnt_t (holds counts 0..2).
  - Lane encoding constants LANE0..LANE3.
- Sub-module demux4_lane_buf: one 2-entry FIFO with signals push, pop, wdata, rdata, valid, full. It is instantiated four times by a generate loop.
- The top level holds the sel decode and the in_ready mux.

Test Plan:
- Reset: drive rst=1 with in_valid=1, in_sel=2, in_data=3 → after the edge, out_valid=0000 and in_ready=1; with the counter feature, lane_cnt=0.
- Basic routing: with out_ready=1111, send (sel,data)=(0,1),(1,2),(2,3),(3,0) on consecutive cycles → each lane shows valid for one cycle with its data, one cycle after acceptance.
- Backpressure:
  - Hold out_ready[2]=0 and push 3 words to lane 2 → first two accepted, in_ready=0 on the third.
  - Switching in_sel to 1 raises in_ready, and lane 1 accepts.
  - Releasing out_ready[2] delivers the lane 2 words in order.
- Simultaneous push/pop at count=1 on lane 0: head=1, push 2 while popping → next cycle head=2, out_valid[0]=1, count=1.
- Reset mid-operation: lanes 1 and 3 full, assert rst for one cycle → all out_valid=0, and the previously buffered words never appear.
- Counters (DEMUX4_CNT_EN): push 256 words to lane 1 → lane 1 count wraps to 0. Pulse cnt_clr during a lane 0 push → lane 0 count reads 0.

Source files
------------

// File: rtl/demux4_pkg.sv
// Shared types and lane encodings for the 1-to-4 stream demultiplexer.
package demux4_pkg;

  localparam int NLANES = 4;

  typedef logic [1:0] lane_sel_t;
  typedef logic [1:0] lane_cnt_t;

  localparam lane_sel_t LANE0 = 2'd0;
  localparam lane_sel_t LANE1 = 2'd1;
  localparam lane_sel_t LANE2 = 2'd2;
  localparam lane_sel_t LANE3 = 2'd3;

endpackage

// File: rtl/demux4_lane_buf.sv
// Two-entry circular FIFO for one output lane; head word is read straight from
// the storage flops, so the lane output never sees the write data combinationally.
module demux4_lane_buf
  import demux4_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic         full
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  lane_cnt_t    count_q, count_d;
  logic         do_push_s, do_pop_s;

  assign valid = (count_q != 2'd0);
  assign full  = (count_q == lane_cnt_t'(DEPTH));
  assign rdata = mem_q[rptr_q];

  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && valid;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (do_push_s) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = ~wptr_q;
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = ~rptr_q;
    end else begin
      rptr_d = rptr_q;
    end
    // Push and pop together leave the occupancy unchanged.
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 valid/ready demultiplexer with a 2-entry buffer per lane.
// Define DEMUX4_CNT_EN to add per-lane 8-bit accepted-push counters (cnt_clr, lane_cnt).
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  lane_sel_t           in_sel,
  output logic [NLANES-1:0]   out_valid,
  input  logic [NLANES-1:0]   out_ready,
  output logic [NLANES*W-1:0] out_data
`ifdef DEMUX4_CNT_EN
  ,
  input  logic                cnt_clr,
  output logic [NLANES*8-1:0] lane_cnt
`endif
);

  logic [NLANES-1:0] full_s;
  logic [NLANES-1:0] push_s;

  // Readiness comes only from registered lane occupancy, never from out_ready.
  always_comb begin
    in_ready = ~full_s[in_sel];
  end

  always_comb begin
    push_s = 4'b0000;
    if (in_valid && in_ready) begin
      case (in_sel)
        LANE0:   push_s = 4'b0001;
        LANE1:   push_s = 4'b0010;
        LANE2:   push_s = 4'b0100;
        LANE3:   push_s = 4'b1000;
        default: push_s = 4'b0000;
      endcase
    end else begin
      push_s = 4'b0000;
    end
  end

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    demux4_lane_buf #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s[i]),
      .pop   (out_ready[i]),
      .wdata (in_data),
      .rdata (out_data[i*W +: W]),
      .valid (out_valid[i]),
      .full  (full_s[i])
    );

`ifdef DEMUX4_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
      if (cnt_clr) begin
        cnt_d = 8'd0;
      end else if (push_s[i]) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= 8'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign lane_cnt[i*8 +: 8] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: vector table plus per-lane queue scoreboard.
module tb_demux4_stream;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
`ifdef DEMUX4_CNT_EN
  logic        cnt_clr;
  logic [31:0] lane_cnt;
`endif

  demux4_stream #(.W(2), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX4_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .lane_cnt  (lane_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] sb_q [4][$];
  logic [7:0] cnt_m [4];

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [1:0] data;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
  } vec_t;

  vec_t tbl [19];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // One clock: drive at negedge, check in_ready before the edge, check lanes after it.
  task automatic step(input logic v, input logic [1:0] sel, input logic [1:0] d,
                      input logic [3:0] ordy, input logic r, input logic clr,
                      output logic rdy_o, output logic [3:0] ov_o);
    logic acc;
    @(negedge clk);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    rst       = r;
`ifdef DEMUX4_CNT_EN
    cnt_clr   = clr;
`endif
    #1;
    rdy_o = in_ready;
    acc   = v && (sb_q[sel].size() != 2);
    if (r) begin
      for (int l = 0; l < 4; l++) begin
        sb_q[l].delete();
        cnt_m[l] = 8'd0;
      end
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, sb_q[sel].size() != 2});
      for (int l = 0; l < 4; l++) begin
        if (ordy[l] && sb_q[l].size() != 0) void'(sb_q[l].pop_front());
      end
      if (acc) sb_q[sel].push_back(d);
      for (int l = 0; l < 4; l++) begin
        if (clr) cnt_m[l] = 8'd0;
        else if (acc && sel == l[1:0]) cnt_m[l] = cnt_m[l] + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    ov_o = out_valid;
    for (int l = 0; l < 4; l++) begin
      check($sformatf("out_valid[%0d]", l), {31'd0, out_valid[l]}, {31'd0, sb_q[l].size() != 0});
      if (sb_q[l].size() != 0)
        check($sformatf("out_data[%0d]", l), {30'd0, out_data[l*2 +: 2]}, {30'd0, sb_q[l][0]});
`ifdef DEMUX4_CNT_EN
      check($sformatf("lane_cnt[%0d]", l), {24'd0, lane_cnt[l*8 +: 8]}, {24'd0, cnt_m[l]});
`endif
    end
  endtask

  logic       rdy;
  logic [3:0] ov;

  initial begin
    // Routing, backpressure, same-lane push/pop, full lane that pops stays unready.
    tbl[0]  = '{1'b1, 2'd0, 2'd1, 4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{1'b1, 2'd1, 2'd2, 4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{1'b1, 2'd2, 2'd3, 4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{1'b1, 2'd3, 2'd0, 4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{1'b0, 2'd0, 2'd0, 4'b1111, 1'b1, 4'b0000};
    tbl[5]  = '{1'b1, 2'd2, 2'd1, 4'b1011, 1'b1, 4'b0100};
    tbl[6]  = '{1'b1, 2'd2, 2'd2, 4'b1011, 1'b1, 4'b0100};
    tbl[7]  = '{1'b1, 2'd2, 2'd3, 4'b1011, 1'b0, 4'b0100};
    tbl[8]  = '{1'b1, 2'd1, 2'd3, 4'b1011, 1'b1, 4'b0110};
    tbl[9]  = '{1'b0, 2'd0, 2'd0, 4'b1011, 1'b1, 4'b0100};
    tbl[10] = '{1'b0, 2'd2, 2'd0, 4'b1111, 1'b0, 4'b0100};
    tbl[11] = '{1'b0, 2'd0, 2'd0, 4'b1111, 1'b1, 4'b0000};
    tbl[12] = '{1'b1, 2'd0, 2'd1, 4'b0000, 1'b1, 4'b0001};
    tbl[13] = '{1'b1, 2'd0, 2'd2, 4'b0001, 1'b1, 4'b0001};
    tbl[14] = '{1'b0, 2'd0, 2'd0, 4'b0001, 1'b1, 4'b0000};
    tbl[15] = '{1'b1, 2'd3, 2'd1, 4'b0000, 1'b1, 4'b1000};
    tbl[16] = '{1'b1, 2'd3, 2'd2, 4'b0000, 1'b1, 4'b1000};
    tbl[17] = '{1'b1, 2'd3, 2'd3, 4'b1000, 1'b0, 4'b1000};
    tbl[18] = '{1'b0, 2'd3, 2'd0, 4'b1000, 1'b1, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 2'd0; out_ready = 4'b0000;
`ifdef DEMUX4_CNT_EN
    cnt_clr = 1'b0;
`endif
    for (int l = 0; l < 4; l++) cnt_m[l] = 8'd0;

    // Reset with a live push on the input: reset must win.
    step(1'b1, 2'd2, 2'd3, 4'b0000, 1'b1, 1'b0, rdy, ov);
    check("reset_out_valid", {28'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_data", {24'd0, out_data}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ordy, 1'b0, 1'b0, rdy, ov);
      check($sformatf("tbl%0d_in_ready", i), {31'd0, rdy}, {31'd0, tbl[i].exp_rdy});
      check($sformatf("tbl%0d_out_valid", i), {28'd0, ov}, {28'd0, tbl[i].exp_ov});
    end

    // Fill lanes 1 and 3, then reset mid-stream: buffered words must vanish.
    step(1'b1, 2'd1, 2'd1, 4'b0000, 1'b0, 1'b0, rdy, ov);
    step(1'b1, 2'd1, 2'd2, 4'b0000, 1'b0, 1'b0, rdy, ov);
    step(1'b1, 2'd3, 2'd3, 4'b0000, 1'b0, 1'b0, rdy, ov);
    step(1'b1, 2'd3, 2'd1, 4'b0000, 1'b0, 1'b0, rdy, ov);
    check("prefill_out_valid", {28'd0, ov}, 32'd10);
    step(1'b1, 2'd2, 2'd3, 4'b1111, 1'b1, 1'b0, rdy, ov);
    check("midreset_out_valid", {28'd0, out_valid}, 32'd0);
    check("midreset_out_data", {24'd0, out_data}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd1, 2'd0, 4'b1111, 1'b0, 1'b0, rdy, ov);
      check("postreset_out_valid", {28'd0, ov}, 32'd0);
    end

`ifdef DEMUX4_CNT_EN
    // 256 pushes to lane 1 wrap its counter back to zero.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 2'd1, i[1:0], 4'b1111, 1'b0, 1'b0, rdy, ov);
    end
    check("cnt_wrap_lane1", {24'd0, lane_cnt[15:8]}, 32'd0);
    step(1'b1, 2'd0, 2'd1, 4'b1111, 1'b0, 1'b1, rdy, ov);
    check("cnt_clr_lane0", {24'd0, lane_cnt[7:0]}, 32'd0);
    step(1'b1, 2'd0, 2'd2, 4'b1111, 1'b0, 1'b0, rdy, ov);
    check("cnt_after_clr_lane0", {24'd0, lane_cnt[7:0]}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
